// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (boot settle, halted, running)
//   ifid_t        : IF/ID pipeline register contents
// The optional misaligned-redirect check is enabled by defining FETCH_MISALIGN_CHK_EN.
package fetch_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_HALT = 2'd1,
        S_RUN  = 2'd2
    } fetch_state_e;

    // Address fields are sized by XLEN_DEF; the top must be built with XLEN == XLEN_DEF.
    typedef struct packed {
        logic                valid;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] pc_plus4;
        logic [31:0]         instr;
    } ifid_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset (pc <= RESET_PC)
//   load      : take load_pc (word aligned, low two bits cleared)
//   load_pc   : redirect target
//   advance   : pc <= pc + 4 (wraps modulo 2^XLEN)
//   pc        : current fetch address
// load has priority over advance; neither asserted means hold.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = load_pc & ~XLEN'(3);
        end else if (advance) begin
            pc_next = pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory, captures the
// combinational read data into the IF/ID register and handles stall, redirect and halt.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   imem_addr       : fetch address (always equal to pc)
//   imem_rdata      : combinational instruction memory read data
//   stall           : hold pc and IF/ID
//   redirect_valid  : load redirect_pc, flush IF/ID, resume running
//   redirect_pc     : redirect target
//   halt_req        : stop fetching, flush IF/ID
//   if_valid, if_pc, if_pc_plus4, if_instr : IF/ID outputs (if_instr = NOP when invalid)
//   fetch_halted    : FSM in S_HALT
//   fetch_fault     : sticky misaligned-redirect flag
// Build option FETCH_MISALIGN_CHK_EN: a redirect with redirect_pc[1:0] != 0 is refused,
// the stage halts and fetch_fault sets. Without it the target is word-aligned on load and
// fetch_fault is constant 0.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [31:0]     if_instr,
    output logic            fetch_halted,
    output logic            fetch_fault
);

    fetch_state_e    state, state_next;
    ifid_t           ifid, ifid_next;
    logic [XLEN-1:0] pc;
    logic            pc_load;
    logic            pc_advance;
    logic            misaligned;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .advance (pc_advance),
        .pc      (pc)
    );

`ifdef FETCH_MISALIGN_CHK_EN
    logic fault_q;

    assign misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else if (redirect_valid && misaligned) begin
            fault_q <= 1'b1;
        end
    end

    assign fetch_fault = fault_q;
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Redirect overrides everything in every state; S_BOOT spends one cycle letting
    // the memory read settle before the first capture.
    always_comb begin
        state_next = state;
        ifid_next  = ifid;
        pc_load    = 1'b0;
        pc_advance = 1'b0;
        if (redirect_valid) begin
            ifid_next.valid = 1'b0;
            if (misaligned) begin
                state_next = S_HALT;
            end else begin
                pc_load    = 1'b1;
                state_next = S_RUN;
            end
        end else begin
            case (state)
                S_BOOT: state_next = S_RUN;
                S_RUN: begin
                    if (halt_req) begin
                        ifid_next.valid = 1'b0;
                        state_next      = S_HALT;
                    end else if (!stall) begin
                        ifid_next.valid    = 1'b1;
                        ifid_next.pc       = pc;
                        ifid_next.pc_plus4 = pc + XLEN'(4);
                        ifid_next.instr    = imem_rdata;
                        pc_advance         = 1'b1;
                    end
                end
                S_HALT: state_next = S_HALT;
                default: state_next = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_BOOT;
            ifid.valid    <= 1'b0;
            ifid.pc       <= '0;
            ifid.pc_plus4 <= '0;
            ifid.instr    <= NOP_INSTR;
        end else begin
            state <= state_next;
            ifid  <= ifid_next;
        end
    end

    assign imem_addr    = pc;
    assign if_valid     = ifid.valid;
    assign if_pc        = ifid.pc;
    assign if_pc_plus4  = ifid.pc_plus4;
    assign if_instr     = ifid.valid ? ifid.instr : NOP_INSTR;
    assign fetch_halted = (state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall/redirect/halt traffic
// and asynchronous resets, all checked against a cycle-level behavioural model.
// The instruction memory returns word_index + 1 for every address.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        fetch_halted;
    logic        fetch_fault;

    int vectors     = 0;
    int miscompares = 0;

    // reference model
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
    bit          m_valid, m_boot, m_halt, m_fault;

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr >> 2) + 32'd1;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr),
        .fetch_halted   (fetch_halted),
        .fetch_fault    (fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_ifpc  = 32'h0;
        m_ifpc4 = 32'h0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        m_fault = 1'b0;
    endtask

    // One rising edge of the fetch stage, in priority order.
    task automatic model_step();
        logic [31:0] word;
        word = (m_pc >> 2) + 32'd1;
        if (redirect_valid) begin
            m_valid = 1'b0;
            m_boot  = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            if (redirect_pc % 4 != 0) begin
                m_halt  = 1'b1;
                m_fault = 1'b1;
            end else begin
                m_pc   = redirect_pc;
                m_halt = 1'b0;
            end
`else
            m_pc   = redirect_pc - (redirect_pc % 4);
            m_halt = 1'b0;
`endif
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (halt_req) begin
            m_valid = 1'b0;
            m_halt  = 1'b1;
        end else if (!stall) begin
            m_valid = 1'b1;
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_instr = word;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".if_valid"}, 32'(if_valid), 32'(m_valid));
        chk({tag, ".if_pc"}, if_pc, m_ifpc);
        chk({tag, ".if_pc_plus4"}, if_pc_plus4, m_ifpc4);
        chk({tag, ".if_instr"}, if_instr, m_valid ? m_instr : NOP);
        chk({tag, ".halted"}, 32'(fetch_halted), 32'(m_halt));
        chk({tag, ".fault"}, 32'(fetch_fault), 32'(m_fault));
    endtask

    task automatic step(input string tag, input bit s, input bit rv, input logic [31:0] rpc,
                        input bit h);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = h;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    // Called just after a negedge: reset lands between edges and must act immediately.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b1;

        // boot cycle then sequential fetch
        step("boot", 0, 0, 0, 0);
        chk("t1_boot_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 3; i++) step("seq", 0, 0, 0, 0);
        chk("t1_if_pc", if_pc, 32'h8);
        chk("t1_if_instr", if_instr, 32'd3);

        // stall holds everything
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 0);
        chk("t2_if_pc", if_pc, 32'h8);
        chk("t2_if_instr", if_instr, 32'd3);
        chk("t2_imem_addr", imem_addr, 32'hC);

        // redirect wins over stall
        step("redir_stall", 1, 1, 32'h40, 0);
        chk("t3_valid", 32'(if_valid), 32'd0);
        chk("t3_imem_addr", imem_addr, 32'h40);
        step("redir_next", 0, 0, 0, 0);
        chk("t3_if_pc", if_pc, 32'h40);
        chk("t3_if_valid", 32'(if_valid), 32'd1);

        // halt, then resume via redirect
        step("halt", 0, 0, 0, 1);
        chk("t4_halted", 32'(fetch_halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step("halted", 1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)));
            chk("t4_frozen", imem_addr, 32'h44);
        end
        step("resume", 0, 1, 32'h100, 0);
        step("resume_fetch", 0, 0, 0, 0);
        chk("t4_if_pc", if_pc, 32'h100);

        // pc + 4 wraps
        step("wrap_redir", 0, 1, 32'hFFFF_FFFC, 0);
        step("wrap_a", 0, 0, 0, 0);
        chk("t5_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5_plus4", if_pc_plus4, 32'h0);
        step("wrap_b", 0, 0, 0, 0);
        chk("t5_if_pc_next", if_pc, 32'h0);

        // misaligned redirect
        step("misalign", 0, 1, 32'h42, 0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t6_fault", 32'(fetch_fault), 32'd1);
        chk("t6_halted", 32'(fetch_halted), 32'd1);
        chk("t6_pc_kept", imem_addr, 32'h4);
        step("misalign_resume", 0, 1, 32'h200, 0);
        chk("t6_fault_sticky", 32'(fetch_fault), 32'd1);
`else
        chk("t6_pc_aligned", imem_addr, 32'h40);
        chk("t6_no_fault", 32'(fetch_fault), 32'd0);
`endif
        step("run", 1, 0, 0, 0);
        async_reset("t6_async_rst");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rpc = $urandom();
            if ($urandom_range(0, 3) != 0) rpc = rpc & 32'hFFFF_FFFC;
            step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0), rpc,
                 1'($urandom_range(0, 14) == 0));
            if ($urandom_range(0, 99) == 0) async_reset("rand_async_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
